load_store_unit: RTL and testbench

Multi-cycle load/store unit between the ALU address output and the register file write port. Accepts one load or store at a time from the core and runs it against a handshaked data memory. Handles RISC-V byte, halfword and word widths, and performs lane steering, byte enables and sign or zero extension. Drives the register file write port (A3/WD3/WE3) directly with the load result.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_if.sv | 45 ++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 codes, byte-enable bases and FSM states for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESP      = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Brief    : Core request, register writeback and data-memory bus of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err;
  logic        busy;

  // Environment side: the core issuing requests and the memory answering them.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_we, wb_rd, wb_data, done, err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_we, wb_rd, wb_data, done, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Store lane steering, load extraction/extension and legality check.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        ok
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_legal;
  logic        w_aligned;

  assign w_byte = rdata[{lane, 3'b000} +: 8];
  assign w_half = rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    be      = BE_WORD;
    st_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        be      = BE_BYTE << lane;
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be      = BE_HALF << lane;
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   ld_data = {24'd0, w_byte};
      F3_H:    ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   ld_data = {16'd0, w_half};
      default: ld_data = rdata;
    endcase
  end

  // Unsigned variants exist only for loads.
  assign w_legal = we ? (funct3 inside {F3_B, F3_H, F3_W})
                      : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

  always_comb begin
    case (funct3[1:0])
      2'b01:   w_aligned = ~lane[0];
      2'b10:   w_aligned = (lane == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign ok = w_legal && w_aligned;

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Multi-cycle load/store FSM between the core and handshaked memory.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic  CLK,
  input  logic  rst,
  lsu_if.slave  bus
);

  localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

  lsu_state_e  r_state, w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;
  logic        r_mem_valid, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_wb_we, r_done, r_err;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_idle, w_we, w_ok, w_accept, w_timeout, w_err_d, w_ld_done;
  logic [2:0]  w_funct3;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_st_data, w_ld_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle && bus.req_valid;
  assign w_timeout = (r_cnt == c_to_last);

  // The checker sees the live request in IDLE and the latched one afterwards.
  assign w_we     = w_idle ? bus.req_we         : r_we;
  assign w_funct3 = w_idle ? bus.req_funct3     : r_funct3;
  assign w_lane   = w_idle ? bus.req_addr[1:0]  : r_lane;

  lsu_align u_align (
    .we      (w_we),
    .funct3  (w_funct3),
    .lane    (w_lane),
    .wdata   (bus.req_wdata),
    .rdata   (bus.mem_rdata),
    .be      (w_be),
    .st_data (w_st_data),
    .ld_data (w_ld_data),
    .ok      (w_ok)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.req_valid) w_next = w_ok ? ST_ISSUE : ST_RESP;
      ST_ISSUE:     if (bus.mem_ready) w_next = r_we ? ST_RESP : ST_WAIT_RESP;
                    else if (w_timeout) w_next = ST_RESP;
      ST_WAIT_RESP: if (bus.mem_rvalid || w_timeout) w_next = ST_RESP;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_err_d   = 1'b0;
    w_ld_done = 1'b0;
    case (r_state)
      ST_IDLE:      w_err_d = w_accept && !w_ok;
      ST_ISSUE:     w_err_d = !bus.mem_ready && w_timeout;
      ST_WAIT_RESP: begin
        w_ld_done = bus.mem_rvalid;
        w_err_d   = !bus.mem_rvalid && w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0;  r_funct3 <= 3'd0;  r_lane <= 2'd0;  r_rd <= 5'd0;  r_cnt <= 8'd0;
      r_mem_valid <= 1'b0;  r_mem_we <= 1'b0;  r_mem_addr <= 32'd0;
      r_mem_be <= 4'd0;  r_mem_wdata <= 32'd0;
      r_wb_we <= 1'b0;  r_wb_rd <= 5'd0;  r_wb_data <= 32'd0;
      r_done <= 1'b0;  r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_lane   <= bus.req_addr[1:0];
        r_rd     <= bus.req_rd;
        if (w_ok) begin
          r_mem_we    <= bus.req_we;
          r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_st_data;
        end
      end
      // Cleared on every state change, so it restarts on entry to ISSUE and WAIT_RESP.
      if (w_next != r_state)
        r_cnt <= 8'd0;
      else if (r_state == ST_ISSUE || r_state == ST_WAIT_RESP)
        r_cnt <= r_cnt + 8'd1;
      r_mem_valid <= (w_next == ST_ISSUE);
      r_done      <= (w_next == ST_RESP);
      r_err       <= w_err_d;
      r_wb_we     <= w_ld_done && (r_rd != 5'd0);
      if (w_ld_done) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_ld_data;
      end
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wb_we     = r_wb_we;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Transaction-level model bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TO = 8;

  logic CLK;
  logic rst;
  lsu_if bus ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  bit          e_ready, e_busy, e_mv, e_done, e_err, e_wbwe, e_mwe;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [4:0]  m_wb_rd   = 5'd0;
  logic [31:0] m_wb_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- specification model ----------------
  function automatic bit is_legal(input bit we, input bit [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int size_of(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_aligned(input bit [2:0] f3, input logic [31:0] addr);
    return (addr % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input bit [2:0] f3, input logic [31:0] addr);
    int b;
    b = ((1 << size_of(f3)) - 1) << (addr % 4);
    return b[3:0];
  endfunction

  function automatic logic [31:0] exp_st(input bit [2:0] f3, input logic [31:0] w);
    if (size_of(f3) == 1) return (w & 32'hFF) * 32'h01010101;
    if (size_of(f3) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input bit [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int          sz;
    logic [31:0] v, mask;
    sz = size_of(f3);
    if (sz == 4) return rdata;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = (rdata >> (8 * (addr % 4))) & mask;
    if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- per-cycle comparison ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, e_ready});
      chk("busy",      {31'd0, bus.busy},      {31'd0, e_busy});
      chk("mem_valid", {31'd0, bus.mem_valid}, {31'd0, e_mv});
      chk("done",      {31'd0, bus.done},      {31'd0, e_done});
      chk("err",       {31'd0, bus.err},       {31'd0, e_err});
      chk("wb_we",     {31'd0, bus.wb_we},     {31'd0, e_wbwe});
      chk("wb_rd",     {27'd0, bus.wb_rd},     {27'd0, m_wb_rd});
      chk("wb_data",   bus.wb_data,            m_wb_data);
      if (e_mv) begin
        chk("mem_we",   {31'd0, bus.mem_we}, {31'd0, e_mwe});
        chk("mem_addr", bus.mem_addr,        e_addr);
        chk("mem_be",   {28'd0, bus.mem_be}, {28'd0, e_be});
        if (e_mwe) chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_exp(input bit rdy, input bit bsy, input bit mv, input bit dn,
                         input bit er, input bit wbwe);
    e_ready = rdy; e_busy = bsy; e_mv = mv; e_done = dn; e_err = er; e_wbwe = wbwe;
  endtask

  // Inputs that a busy unit must ignore get random values.
  task automatic noise();
    bus.req_valid  = 1'($urandom);
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd     = 5'($urandom);
    bus.mem_ready  = 1'($urandom);
    bus.mem_rvalid = 1'($urandom);
    bus.mem_rdata  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      bus.req_valid = 1'b0;
      set_exp(1, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic run(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input int rdy_dly,
                     input int rv_dly, input logic [31:0] rdata);
    bit ok, tmo;
    ok = is_legal(we, f3) && is_aligned(f3, addr);
    noise();
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr;  bus.req_wdata = wdata; bus.req_rd = rd;
    set_exp(1, 0, 0, 0, 0, 0);
    step();
    if (!ok) begin
      noise();
      set_exp(0, 1, 0, 1, 1, 0);
      step();
      return;
    end
    e_mwe = we; e_addr = {addr[31:2], 2'b00}; e_be = exp_be(f3, addr); e_wdata = exp_st(f3, wdata);
    tmo = 0;
    for (int i = 0; i < TO; i++) begin
      noise();
      bus.mem_ready = (i == rdy_dly);
      set_exp(0, 1, 1, 0, 0, 0);
      step();
      if (i == rdy_dly) break;
      if (i == TO - 1) tmo = 1;
    end
    if (!tmo && !we) begin
      for (int j = 0; j < TO; j++) begin
        noise();
        bus.mem_rvalid = (j == rv_dly);
        if (j == rv_dly) bus.mem_rdata = rdata;
        set_exp(0, 1, 0, 0, 0, 0);
        step();
        if (j == rv_dly) break;
        if (j == TO - 1) tmo = 1;
      end
    end
    noise();
    if (tmo) set_exp(0, 1, 0, 1, 1, 0);
    else if (we) set_exp(0, 1, 0, 1, 0, 0);
    else begin
      m_wb_rd   = rd;
      m_wb_data = exp_ld(f3, addr, rdata);
      set_exp(0, 1, 0, 1, 0, rd != 5'd0);
    end
    step();
  endtask

  task automatic reset_mid_load();
    noise();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h300; bus.req_rd = 5'd7;
    set_exp(1, 0, 0, 0, 0, 0);
    step();
    noise();
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0;
    e_mwe = 1'b0; e_addr = 32'h300; e_be = 4'hF; e_wdata = 32'd0;
    set_exp(0, 1, 1, 0, 0, 0);
    step();
    bus.req_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    set_exp(0, 1, 0, 0, 0, 0);
    #2;
    chk_en = 0;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr,           32'd0);
    chk("rst_mem_be",    {28'd0, bus.mem_be},    32'd0);
    chk("rst_wb_data",   bus.wb_data,            32'd0);
    chk("rst_done",      {31'd0, bus.done},      32'd0);
    rst = 1'b0;
    m_wb_rd = 5'd0; m_wb_data = 32'd0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    set_exp(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    step();
    bus.mem_rvalid = 1'b1;
    step();
    idle(2);
  endtask

  bit [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    bit          we;
    bit [2:0]    f3;
    logic [31:0] addr;
    int          rdy, rv;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_rd = 5'd0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'd0;
    step();
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_busy",      {31'd0, bus.busy},      32'd0);
    chk("reset_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("reset_mem_wdata", bus.mem_wdata,          32'd0);
    chk("reset_wb_rd",     {27'd0, bus.wb_rd},     32'd0);
    chk("reset_done_err",  {30'd0, bus.done, bus.err}, 32'd0);
    rst = 1'b0;
    chk_en = 1;
    idle(2);

    // Hand-computed values that pin the model itself.
    chk("pin_be_sh",   {28'd0, exp_be(3'b001, 32'h202)}, 32'h0000000C);
    chk("pin_st_sh",   exp_st(3'b001, 32'h0000ABCD),      32'hABCDABCD);
    chk("pin_st_sb",   exp_st(3'b000, 32'h12345678),      32'h78787878);
    chk("pin_ld_lb",   exp_ld(3'b000, 32'h103, 32'h80FF0000), 32'hFFFFFF80);

    run(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, 0, 0, 32'd0);
    run(0, 3'b000, 32'h103, 32'd0, 5'd5, 0, 0, 32'h80FF0000);
    chk("lb_wb_data", bus.wb_data, 32'hFFFFFF80);
    chk("lb_wb_rd",   {27'd0, bus.wb_rd}, 32'd5);
    run(0, 3'b100, 32'h103, 32'd0, 5'd5, 0, 0, 32'h80FF0000);
    chk("lbu_wb_data", bus.wb_data, 32'h00000080);
    run(1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 0, 0, 32'd0);
    run(0, 3'b101, 32'h202, 32'd0, 5'd9, 0, 0, 32'h1234ABCD);
    chk("lhu_wb_data", bus.wb_data, 32'h00001234);
    run(0, 3'b010, 32'h101, 32'd0, 5'd4, 0, 0, 32'd0);
    run(0, 3'b011, 32'h100, 32'd0, 5'd4, 0, 0, 32'd0);
    run(1, 3'b011, 32'h100, 32'd0, 5'd4, 0, 0, 32'd0);
    run(0, 3'b010, 32'h400, 32'd0, 5'd12, 3, 2, 32'h13572468);
    chk("slow_lw_wb_data", bus.wb_data, 32'h13572468);
    run(0, 3'b010, 32'h404, 32'd0, 5'd13, 0, 100, 32'd0);
    run(1, 3'b000, 32'h405, 32'h55, 5'd0, 100, 0, 32'd0);
    run(0, 3'b010, 32'h408, 32'd0, 5'd0, 1, 1, 32'h0BADF00D);
    chk("rd0_wb_data", bus.wb_data, 32'h0BADF00D);
    idle(1);
    reset_mid_load();

    for (int t = 0; t < 400; t++) begin
      we = 1'($urandom);
      if ($urandom % 8 == 0) f3 = 3'($urandom);
      else if (we)           f3 = 3'($urandom % 3);
      else                   f3 = ld_f3[$urandom % 5];
      addr = $urandom;
      if ($urandom % 4 != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      rdy = ($urandom % 10 == 0) ? TO - 1 + int'($urandom % 3) : int'($urandom % 4);
      rv  = ($urandom % 10 == 0) ? TO - 1 + int'($urandom % 3) : int'($urandom % 4);
      run(we, f3, addr, $urandom, 5'($urandom), rdy, rv, $urandom);
      idle(int'($urandom % 3));
    end

    idle(2);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
